// File: rtl/mem_access_ctrl_if.sv
// Memory-bus interface between the load/store controller (master) and the
// data-memory port (slave). A request is held on bus_req until bus_gnt. The
// transaction then completes on bus_rvalid for a load or on bus_wack for a store.
interface mem_access_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [7:0]      bus_wstrb;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_wack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_wack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata, bus_wack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns one load/store from the EX/MEM register into one
// memory-bus transaction. The block aligns and formats the data. It returns a
// one-cycle done pulse to the pipeline control unit.
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap accesses that are not
// naturally aligned. A trapped access issues no bus cycle and gets a done pulse
// with misalign set.
module mem_access_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              req_flushed_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   wdata_i,
    mem_access_ctrl_if.master bus,
    output logic              read_done_o,
    output logic              write_done_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e          state_q;
    logic            is_store_q;
    logic            abort_q;
    logic [2:0]      funct3_q;
    logic [2:0]      lane_q;
    logic            bus_req_q;
    logic            bus_we_q;
    logic [XLEN-1:0] bus_addr_q;
    logic [XLEN-1:0] bus_wdata_q;
    logic [7:0]      bus_wstrb_q;
    logic            read_done_q;
    logic            write_done_q;
    logic [XLEN-1:0] load_data_q;

    logic            accept;
    logic            abort_now;
    logic            rsp_seen;
    logic [7:0]      size_mask;
    logic [7:0]      wstrb_in;
    logic [XLEN-1:0] wdata_in;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_fmt;

    // The FSM accepts a new request only from a live (non-bubble) EX/MEM entry.
    // Once the transaction is underway, a flush or a dropped request marks it
    // as abandoned.
    assign accept    = (mem_read_i | mem_write_i) & ~req_flushed_i;
    assign abort_now = abort_q | req_flushed_i | ~(mem_read_i | mem_write_i);
    assign rsp_seen  = is_store_q ? bus.bus_wack : bus.bus_rvalid;

    // Store lane placement: the size mask and the data both move up to the byte lane.
    // Any bytes shifted past lane 7 are dropped.
    always_comb begin
        size_mask = 8'h01;
        unique case (funct3_i[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        wstrb_in = size_mask << addr_i[2:0];
        wdata_in = wdata_i << {addr_i[2:0], 3'b000};
    end

    // Load formatting: shift the read beat down to bit 0, then sign- or
    // zero-extend it according to the access size.
    always_comb begin
        rd_shift = bus.bus_rdata >> {lane_q, 3'b000};
        load_fmt = '0;
        unique case (funct3_q)
            3'b000:  load_fmt = {{(XLEN-8){rd_shift[7]}},   rd_shift[7:0]};
            3'b001:  load_fmt = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_fmt = {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  load_fmt = rd_shift;
            3'b100:  load_fmt = {{(XLEN-8){1'b0}},  rd_shift[7:0]};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            3'b110:  load_fmt = {{(XLEN-32){1'b0}}, rd_shift[31:0]};
            default: load_fmt = '0;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misaligned_in;
    logic misalign_q;

    // An access is misaligned when any address bit below its size is set.
    always_comb begin
        misaligned_in = 1'b0;
        unique case (funct3_i[1:0])
            2'd0:    misaligned_in = 1'b0;
            2'd1:    misaligned_in = addr_i[0];
            2'd2:    misaligned_in = |addr_i[1:0];
            default: misaligned_in = |addr_i[2:0];
        endcase
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    // Transaction FSM. Every bus output and pipeline output is registered here.
    // The done pulses default to 0, so they last exactly one cycle in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            abort_q      <= 1'b0;
            funct3_q     <= '0;
            lane_q       <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
            load_data_q  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        is_store_q  <= mem_write_i;
                        abort_q     <= 1'b0;
                        funct3_q    <= funct3_i;
                        lane_q      <= addr_i[2:0];
                        bus_we_q    <= mem_write_i;
                        bus_addr_q  <= {addr_i[XLEN-1:3], 3'b000};
                        bus_wdata_q <= mem_write_i ? wdata_in : '0;
                        bus_wstrb_q <= mem_write_i ? wstrb_in : '0;
`ifdef MEM_MISALIGN_CHECK_EN
                        if (misaligned_in) begin
                            // A trapped access skips the bus entirely.
                            state_q      <= ST_DONE;
                            read_done_q  <= ~mem_write_i;
                            write_done_q <= mem_write_i;
                            misalign_q   <= 1'b1;
                            if (!mem_write_i) begin
                                load_data_q <= '0;
                            end
                        end else begin
                            state_q   <= ST_REQ;
                            bus_req_q <= 1'b1;
                        end
`else
                        state_q   <= ST_REQ;
                        bus_req_q <= 1'b1;
`endif
                    end
                end
                ST_REQ: begin
                    abort_q <= abort_now;
                    if (bus.bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    abort_q <= abort_now;
                    if (rsp_seen) begin
                        if (abort_now) begin
                            // The pipeline has abandoned this access. Absorb the
                            // response and report nothing.
                            state_q <= ST_IDLE;
                        end else begin
                            state_q      <= ST_DONE;
                            read_done_q  <= ~is_store_q;
                            write_done_q <= is_store_q;
                            if (!is_store_q) begin
                                load_data_q <= load_fmt;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_wstrb = bus_wstrb_q;
    assign read_done_o   = read_done_q;
    assign write_done_o  = write_done_q;
    assign load_data_o   = load_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl. Directed scenarios plus randomized loads and
// stores are compared against a byte-level reference model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic        req_flushed;
    logic [63:0] addr;
    logic [2:0]  funct3;
    logic [63:0] wdata;
    logic        read_done;
    logic        write_done;
    logic [63:0] load_data;
    logic        misalign;

    int          n_cmp;
    int          n_err;
    logic [63:0] exp_load;

    mem_access_ctrl_if #(.XLEN(64)) bus_if ();

    mem_access_ctrl #(.XLEN(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .req_flushed_i(req_flushed),
        .addr_i       (addr),
        .funct3_i     (funct3),
        .wdata_i      (wdata),
        .bus          (bus_if.master),
        .read_done_o  (read_done),
        .write_done_o (write_done),
        .load_data_o  (load_data),
        .misalign_o   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-level) ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] model_wstrb(input logic [63:0] a, input logic [2:0] f3);
        logic [7:0] r;
        int unsigned lane;
        lane = a[2:0];
        r = '0;
        for (int unsigned b = 0; b < 8; b++)
            if (b >= lane && b < lane + acc_size(f3)) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] a, input logic [63:0] wd);
        logic [63:0] r;
        int unsigned lane;
        lane = a[2:0];
        r = '0;
        for (int unsigned b = 0; b < 8; b++)
            if (b >= lane) r[8*b +: 8] = wd[8*(b-lane) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3,
                                               input logic [63:0] rd);
        logic [63:0] v;
        int unsigned lane;
        int unsigned sz;
        lane = a[2:0];
        sz   = acc_size(f3);
        v    = '0;
        if (f3 == 3'b111) return '0;
        for (int unsigned i = 0; i < sz; i++)
            if (lane + i < 8) v[8*i +: 8] = rd[8*(lane+i) +: 8];
        if (!f3[2])
            for (int unsigned k = 8*sz; k < 64; k++) v[k] = v[8*sz-1];
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [63:0] a, input logic [2:0] f3);
        return (a % acc_size(f3)) != 0;
    endfunction

    // ---------------- one complete load/store ----------------
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int unsigned gd, input int unsigned rd_dly, input bit early);
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_wstrb;
        bit          mis;
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = model_misaligned(a, f3);
`endif
        e_addr  = a & ~64'h7;
        e_wdata = model_wdata(a, wd);
        e_wstrb = model_wstrb(a, f3);

        @(negedge clk);
        mem_read  = !st;
        mem_write = st;
        addr      = a;
        funct3    = f3;
        wdata     = wd;
        @(posedge clk); #1;
        if (mis) begin
            check("mis_no_req", bus_if.bus_req, 0);
            check("mis_done", st ? write_done : read_done, 1);
            check("mis_flag", misalign, 1);
            if (!st) begin
                exp_load = '0;
                check("mis_load", load_data, exp_load);
            end
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(posedge clk); #1;
            check("mis_clear", {read_done, write_done, misalign}, 0);
            return;
        end
        check("req", bus_if.bus_req, 1);
        check("addr", bus_if.bus_addr, e_addr);
        check("we", bus_if.bus_we, st);
        if (st) begin
            check("wstrb", bus_if.bus_wstrb, e_wstrb);
            check("wdata", bus_if.bus_wdata, e_wdata);
        end
        for (int unsigned i = 0; i < gd; i++) begin
            @(posedge clk); #1;
            check("req_hold", bus_if.bus_req, 1);
            check("addr_hold", bus_if.bus_addr, e_addr);
            check("we_hold", bus_if.bus_we, st);
            if (st) begin
                check("wstrb_hold", bus_if.bus_wstrb, e_wstrb);
                check("wdata_hold", bus_if.bus_wdata, e_wdata);
            end
            check("no_done_req", {read_done, write_done}, 0);
        end
        @(negedge clk);
        bus_if.bus_gnt = 1'b1;
        if (early) begin
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_wack   = 1'b1;
            bus_if.bus_rdata  = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        check("req_drop", bus_if.bus_req, 0);
        check("no_done_gnt", {read_done, write_done}, 0);
        @(negedge clk);
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_wack   = 1'b0;
        for (int unsigned i = 0; i < rd_dly; i++) begin
            @(posedge clk); #1;
            check("no_done_wait", {read_done, write_done}, 0);
            @(negedge clk);
        end
        if (st) bus_if.bus_wack = 1'b1;
        else begin
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_rdata  = rd;
        end
        @(posedge clk); #1;
        check("read_done", read_done, !st);
        check("write_done", write_done, st);
        check("misalign0", misalign, 0);
        if (!st) exp_load = model_load(a, f3, rd);
        check("load_data", load_data, exp_load);
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_wack   = 1'b0;
        bus_if.bus_rdata  = {$urandom, $urandom};
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check("done_clear", {read_done, write_done}, 0);
        check("load_hold", load_data, exp_load);
        check("req_idle", bus_if.bus_req, 0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [2:0]  rf3;
        bit          rst_store;
        n_cmp = 0;
        n_err = 0;
        exp_load = '0;
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        req_flushed = 1'b0;
        addr = '0;
        funct3 = '0;
        wdata = '0;
        bus_if.bus_gnt = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata = '0;
        bus_if.bus_wack = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", bus_if.bus_req, 0);
        check("rst_addr", bus_if.bus_addr, 0);
        check("rst_wdata", bus_if.bus_wdata, 0);
        check("rst_wstrb", bus_if.bus_wstrb, 0);
        check("rst_done", {read_done, write_done, misalign}, 0);
        check("rst_load", load_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LB, minimum latency, negative byte
        run_txn(0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
        check("lb_value", load_data, 64'hFFFF_FFFF_FFFF_FF80);
        // SH into the top two lanes
        run_txn(1, 3'b001, 64'h2006, 64'hABCD, 64'h0, 0, 0, 0);
        // grant withheld five cycles
        run_txn(0, 3'b011, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 1, 0);
        check("ld_value", load_data, 64'h0123_4567_89AB_CDEF);

        // bubble in IDLE must not start a transaction
        @(negedge clk);
        mem_read = 1'b1;
        req_flushed = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("flushed_no_req", bus_if.bus_req, 0);
        end
        @(negedge clk);
        mem_read = 1'b0;
        req_flushed = 1'b0;

        // flush raised during WAIT: response absorbed, no done
        mem_read = 1'b1;
        funct3 = 3'b011;
        addr = 64'h40;
        @(posedge clk); #1;
        check("abort_req", bus_if.bus_req, 1);
        @(negedge clk);
        bus_if.bus_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        req_flushed = 1'b1;
        @(posedge clk); #1;
        check("abort_wait", read_done, 0);
        @(negedge clk);
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        check("abort_no_done", read_done, 0);
        check("abort_load_kept", load_data, exp_load);
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        req_flushed = 1'b0;
        mem_read = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_done", read_done, 0);
        check("abort_idle_req", bus_if.bus_req, 0);
        run_txn(0, 3'b110, 64'h10, 64'h0, 64'h0000_0000_FFFF_FFFF, 0, 0, 0);
        check("lwu_value", load_data, 64'h0000_0000_FFFF_FFFF);

        // reset in WAIT: outputs clear at once, late response ignored
        @(negedge clk);
        mem_read = 1'b1;
        funct3 = 3'b011;
        addr = 64'h88;
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        check("arst_req", bus_if.bus_req, 0);
        check("arst_addr", bus_if.bus_addr, 0);
        check("arst_we", bus_if.bus_we, 0);
        check("arst_done", {read_done, write_done, misalign}, 0);
        check("arst_load", load_data, 0);
        exp_load = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.bus_rvalid = 1'b1;
        @(posedge clk); #1;
        check("arst_late_rsp", read_done, 0);
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        @(posedge clk); #1;
        check("arst_still_idle", {read_done, bus_if.bus_req}, 0);

`ifdef MEM_MISALIGN_CHECK_EN
        run_txn(0, 3'b010, 64'h1002, 64'h0, 64'h0, 0, 0, 0);
`endif

        // randomized loads and stores
        for (int n = 0; n < 60; n++) begin
            rst_store = $urandom_range(0, 1);
            rf3 = rst_store ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            run_txn(rst_store, rf3, ra, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
